// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the configurable UART receiver.
//   state_t  : receiver FSM encodings (IDLE, START, DATA, PAR, STOP)
//   PAR_*    : parity mode constants used by the PARITY parameter
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: input conditioning for the UART receiver.
//   Synchronises the raw line with two flops (idle high), keeps a one-cycle
//   delayed copy for falling-edge detection, and produces the bit value used
//   at each decision tick.
//   Optional macro UART_RX_MAJORITY_EN: the decision bit becomes the 2-of-3
//   majority of the synchronised line at the current and two previous ticks.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   d_in         : raw asynchronous serial line
//   sample_tick  : oversampling tick (only present with UART_RX_MAJORITY_EN)
//   fall         : falling edge seen on the synchronised line
//   bit_s        : sampled bit value to use at a decision tick
module uart_rx_sampler (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
`ifdef UART_RX_MAJORITY_EN
  input  logic sample_tick,
`endif
  output logic fall,
  output logic bit_s
);

  logic sync_q, sync_d;
  logic rx_s_q, rx_s_d;
  logic rx_q, rx_d;

  always_comb begin
    sync_d = d_in;
    rx_s_d = sync_q;
    rx_d   = rx_s_q;
  end

  // Reset to 1 so a released reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 1'b1;
      rx_s_q <= 1'b1;
      rx_q   <= 1'b1;
    end else begin
      sync_q <= sync_d;
      rx_s_q <= rx_s_d;
      rx_q   <= rx_d;
    end
  end

  assign fall = rx_q & ~rx_s_q;

`ifdef UART_RX_MAJORITY_EN
  // History of the line at the two previous ticks; combined with the
  // current value it covers ticks D-2, D-1 and D of any decision.
  logic [1:0] hist_q, hist_d;

  always_comb begin
    hist_d = hist_q;
    if (sample_tick) hist_d = {hist_q[0], rx_s_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist_q <= 2'b11;
    else     hist_q <= hist_d;
  end

  assign bit_s = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
`else
  assign bit_s = rx_s_q;
`endif

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver (data width, parity, stop bits,
// oversampling ratio) with frame and parity error reporting.
//   Optional macro UART_RX_MAJORITY_EN selects 3-sample majority decisions.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   d_in         : raw serial line, idle high
//   rx_en        : arms start detection (an active frame always completes)
//   sample_tick  : OVERSAMPLE pulses per bit from the baud generator
//   rx_baud_en   : baud generator run request, start detection to frame end
//   d_out        : last received payload, held until the next done
//   start, busy  : in START / not in IDLE
//   done         : one-cycle frame-complete pulse
//   parity_err   : parity mismatch of the last frame
//   frame_err    : a stop bit of the last frame was sampled low
module uart_rx_cfg import uart_pkg::*; #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 d_in,
  input  logic                 rx_en,
  input  logic                 sample_tick,
  output logic                 rx_baud_en,
  output logic [DATA_BITS-1:0] d_out,
  output logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  logic rx_fall, rx_bit;

  uart_rx_sampler u_sampler (
    .clk         (clk),
    .rst         (rst),
    .d_in        (d_in),
`ifdef UART_RX_MAJORITY_EN
    .sample_tick (sample_tick),
`endif
    .fall        (rx_fall),
    .bit_s       (rx_bit)
  );

  state_t               state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic                 perr_acc_q, perr_acc_d;
  logic [DATA_BITS-1:0] d_out_q, d_out_d;
  logic                 done_q, done_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 baud_q, baud_d;

  logic start_dec, bit_dec;
  assign start_dec = sample_tick && (tick_q == TW'(OVERSAMPLE/2 - 1));
  assign bit_dec   = sample_tick && (tick_q == TW'(OVERSAMPLE - 1));

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    stop_d     = stop_q;
    shift_d    = shift_q;
    ferr_acc_d = ferr_acc_q;
    perr_acc_d = perr_acc_q;
    d_out_d    = d_out_q;
    done_d     = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    baud_d     = baud_q;

    // OVERSAMPLE is a power of two, so the natural wrap gives OVERSAMPLE-1 -> 0.
    if (sample_tick && state_q != IDLE) tick_d = tick_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (rx_en && rx_fall) begin
          state_d = START;
          tick_d  = '0;
          baud_d  = 1'b1;
        end
      end
      START: begin
        if (start_dec) begin
          if (!rx_bit) begin
            state_d    = DATA;
            tick_d     = '0;
            bit_d      = '0;
            ferr_acc_d = 1'b0;
            perr_acc_d = 1'b0;
          end else begin
            state_d = IDLE;
            baud_d  = 1'b0;
          end
        end
      end
      DATA: begin
        if (bit_dec) begin
          shift_d = {rx_bit, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BW'(DATA_BITS - 1)) begin
            state_d = (PARITY != PAR_NONE) ? PAR : STOP;
            stop_d  = 1'b0;
          end
        end
      end
      PAR: begin
        if (bit_dec) begin
          // Even: error when total XOR is 1; odd: error when it is 0.
          perr_acc_d = (^shift_q) ^ rx_bit ^ (PARITY == PAR_ODD);
          state_d    = STOP;
          stop_d     = 1'b0;
        end
      end
      STOP: begin
        if (bit_dec) begin
          if (!rx_bit) ferr_acc_d = 1'b1;
          if (stop_q == 1'(STOP_BITS - 1)) begin
            // Finish at the stop-bit centre so a back-to-back start is caught.
            d_out_d = shift_q;
            ferr_d  = ferr_acc_q | ~rx_bit;
            perr_d  = (PARITY != PAR_NONE) ? perr_acc_q : 1'b0;
            done_d  = 1'b1;
            baud_d  = 1'b0;
            state_d = IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      stop_q     <= 1'b0;
      shift_q    <= '0;
      ferr_acc_q <= 1'b0;
      perr_acc_q <= 1'b0;
      d_out_q    <= '0;
      done_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      baud_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      stop_q     <= stop_d;
      shift_q    <= shift_d;
      ferr_acc_q <= ferr_acc_d;
      perr_acc_q <= perr_acc_d;
      d_out_q    <= d_out_d;
      done_q     <= done_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      baud_q     <= baud_d;
    end
  end

  assign rx_baud_en = baud_q;
  assign d_out      = d_out_q;
  assign start      = (state_q == START);
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: bench for uart_rx_cfg with three configurations side by
// side: 8N1/x8, 8E1/x8 and 7O2/x16, each with its own serial line.
module tb_uart_rx_cfg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_en = 1'b0;
  logic [2:0] line = 3'b111;
  logic [1:0] div = 2'd0;
  logic       sample_tick;

  always #5 clk = ~clk;
  always @(posedge clk) div <= div + 2'd1;
  assign sample_tick = (div == 2'd0);

  wire [7:0] dout0, dout1;
  wire [6:0] dout2;
  wire [2:0] st, bz, dn, be, pe, fe;

  uart_rx_cfg u0 (
    .clk(clk), .rst(rst), .d_in(line[0]), .rx_en(rx_en), .sample_tick(sample_tick),
    .rx_baud_en(be[0]), .d_out(dout0), .start(st[0]), .busy(bz[0]), .done(dn[0]),
    .parity_err(pe[0]), .frame_err(fe[0])
  );

  uart_rx_cfg #(.PARITY(1)) u1 (
    .clk(clk), .rst(rst), .d_in(line[1]), .rx_en(rx_en), .sample_tick(sample_tick),
    .rx_baud_en(be[1]), .d_out(dout1), .start(st[1]), .busy(bz[1]), .done(dn[1]),
    .parity_err(pe[1]), .frame_err(fe[1])
  );

  uart_rx_cfg #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .OVERSAMPLE(16)) u2 (
    .clk(clk), .rst(rst), .d_in(line[2]), .rx_en(rx_en), .sample_tick(sample_tick),
    .rx_baud_en(be[2]), .d_out(dout2), .start(st[2]), .busy(bz[2]), .done(dn[2]),
    .parity_err(pe[2]), .frame_err(fe[2])
  );

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  typedef struct {
    int         k;
    logic [8:0] data;
    bit         pflip;
    bit         s2low;
    logic       perr;
    logic       ferr;
  } vec_t;

  exp_t q0[$], q1[$], q2[$];
  int total = 0;
  int bad = 0;
  int done_cnt[3] = '{0, 0, 0};
  int push_cnt[3] = '{0, 0, 0};

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  function automatic int qsize(int k);
    if (k == 0) return q0.size();
    if (k == 1) return q1.size();
    return q2.size();
  endfunction

  task automatic push(int k, logic [8:0] data, logic perr, logic ferr);
    exp_t e;
    e.data = data; e.perr = perr; e.ferr = ferr;
    push_cnt[k]++;
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic wait_ticks(int n);
    int c = 0;
    while (c < n) begin
      @(negedge clk);
      if (sample_tick) c++;
    end
  endtask

  // Drive one frame on line k. gbit >= 0 plants a one-tick inverted glitch
  // at the centre of that data bit.
  task automatic send(int k, logic [8:0] data, bit pflip, bit s2low, int gbit);
    int nb, pm, ns, os;
    logic p;
    nb = (k == 2) ? 7 : 8;
    pm = k;
    ns = (k == 2) ? 2 : 1;
    os = (k == 2) ? 16 : 8;
    line[k] = 1'b0;
    wait_ticks(os);
    for (int i = 0; i < nb; i++) begin
      line[k] = data[i];
      if (i == gbit) begin
        wait_ticks(os/2 - 1);
        line[k] = ~data[i];
        wait_ticks(1);
        line[k] = data[i];
        wait_ticks(os/2);
      end else begin
        wait_ticks(os);
      end
    end
    if (pm != 0) begin
      p = 1'b0;
      for (int i = 0; i < nb; i++) p = p ^ data[i];
      if (pm == 2) p = ~p;
      line[k] = p ^ pflip;
      wait_ticks(os);
    end
    for (int s = 0; s < ns; s++) begin
      line[k] = !(s2low && s == 1);
      wait_ticks(os);
    end
    line[k] = 1'b1;
    wait_ticks(2 * os);
  endtask

  // Scoreboard side: compare each done against the oldest expectation.
  logic [2:0] prev_dn = 3'b000;
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (dn[k] === 1'b1) begin
          exp_t e;
          logic [8:0] got;
          bit have;
          got = (k == 0) ? {1'b0, dout0} : (k == 1) ? {1'b0, dout1} : {2'b00, dout2};
          done_cnt[k]++;
          chk($sformatf("u%0d done_width", k), prev_dn[k], 0);
          chk($sformatf("u%0d busy_at_done", k), {bz[k], be[k]}, 0);
          have = (qsize(k) > 0);
          if (have) begin
            case (k)
              0: e = q0.pop_front();
              1: e = q1.pop_front();
              default: e = q2.pop_front();
            endcase
            chk($sformatf("u%0d d_out", k), got, e.data);
            chk($sformatf("u%0d parity_err", k), pe[k], e.perr);
            chk($sformatf("u%0d frame_err", k), fe[k], e.ferr);
          end else begin
            total++;
            bad++;
            $display("FAIL u%0d unexpected_done: got done with d_out %0h, want no done", k, got);
          end
        end
      end
      prev_dn = dn;
    end
  end

  vec_t vt[10];

  initial begin
    vt[0] = '{0, 9'h55, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{0, 9'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[2] = '{0, 9'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3] = '{1, 9'hA3, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4] = '{1, 9'hA3, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[5] = '{1, 9'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[6] = '{2, 9'h5A, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[7] = '{2, 9'h5A, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[8] = '{2, 9'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[9] = '{2, 9'h7F, 1'b1, 1'b0, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk($sformatf("u%0d reset_outputs", k), {st[k], bz[k], dn[k], be[k], pe[k], fe[k]}, 0);
    chk("u0 reset_d_out", dout0, 0);
    rst = 1'b0;
    rx_en = 1'b1;
    wait_ticks(16);

    for (int i = 0; i < 10; i++) begin
      push(vt[i].k, vt[i].data, vt[i].perr, vt[i].ferr);
      send(vt[i].k, vt[i].data, vt[i].pflip, vt[i].s2low, -1);
      chk($sformatf("vec%0d frame_done", i), qsize(vt[i].k), 0);
    end

    // Short low glitch: false start, no done.
    begin
      int base;
      base = done_cnt[0];
      line[0] = 1'b0;
      wait_ticks(1);
      chk("glitch start_busy_baud", {st[0], bz[0], be[0]}, 3'b111);
      wait_ticks(1);
      line[0] = 1'b1;
      wait_ticks(8);
      chk("glitch idle_again", {st[0], bz[0], be[0]}, 0);
      chk("glitch no_done", done_cnt[0], base);
    end

    // Break: whole frame low, then no retrigger while the line stays low.
    push(0, 9'h00, 1'b0, 1'b1);
    line[0] = 1'b0;
    wait_ticks(96);
    chk("break frame_done", qsize(0), 0);
    chk("break no_retrigger", {bz[0], be[0]}, 0);
    line[0] = 1'b1;
    wait_ticks(16);
    push(0, 9'h3C, 1'b0, 1'b0);
    send(0, 9'h3C, 1'b0, 1'b0, -1);
    chk("after_break frame_done", qsize(0), 0);

    // Reset in the middle of the data bits.
    line[0] = 1'b0;
    wait_ticks(8);
    line[0] = 1'b1;
    wait_ticks(12);
    chk("mid_data busy", bz[0], 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_reset outputs", {dout0, st[0], bz[0], dn[0], be[0], pe[0], fe[0]}, 0);
    repeat (4) @(negedge clk);
    line[0] = 1'b1;
    rst = 1'b0;
    wait_ticks(16);
    push(0, 9'hC3, 1'b0, 1'b0);
    send(0, 9'hC3, 1'b0, 1'b0, -1);
    chk("after_reset frame_done", qsize(0), 0);

`ifdef UART_RX_MAJORITY_EN
    push(0, 9'h96, 1'b0, 1'b0);
    send(0, 9'h96, 1'b0, 1'b0, 3);
    chk("majority frame_done", qsize(0), 0);
`endif

    wait_ticks(8);
    for (int k = 0; k < 3; k++)
      chk($sformatf("u%0d done_count", k), done_cnt[k], push_cnt[k]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver, successor of the fixed 8N1 receiver in the serial subsystem. Supports configurable data width, parity, stop-bit count and oversampling ratio, plus a built-in input synchroniser, falling-edge start detection and frame and parity error reporting. It sits between the pad-side serial input and the byte consumer. Sampling ticks come from the shared baud generator.

## Interface
- DATA_BITS, 8, payload bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits; 1 or 2.
- OVERSAMPLE, 8, sample ticks per bit; power of two, 8..16.
- clk  in  1  system clock; one clock domain.
- rst  in  1  asynchronous, active-high reset.
- d_in  in  1  raw serial line; asynchronous; idle high.
- rx_en  in  1  arms start detection; does not abort a frame already in progress.
- sample_tick  in  1  one-cycle pulse from the baud generator, OVERSAMPLE pulses per bit.
- rx_baud_en  out  1  baud-generator run request; high from start detection to frame end.
- d_out  out  DATA_BITS  last received payload, LSB first on the line; held until the next done.
- start  out  1  high while in START.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: frame complete, d_out and error flags valid.
- parity_err  out  1  parity mismatch of the last frame; updated with done; 0 when PARITY = 0.
- frame_err  out  1  any stop bit sampled low in the last frame; updated with done.

## Operation
- Input path:
  - d_in passes through a 2-flop synchroniser to give rx_s.
  - rx_q is rx_s delayed by one cycle.
- States: IDLE, START, DATA, PAR, STOP.
- tick_cnt: $clog2(OVERSAMPLE) bits; advances only on sample_tick; wraps OVERSAMPLE-1 -> 0.
- IDLE:
  - Leave IDLE only when rx_en = 1 and a falling edge is seen (rx_q = 1, rx_s = 0).
  - On that edge go to START, clear tick_cnt, set rx_baud_en.
  - A line stuck low never retriggers a frame.
- START:
  - Decision is taken on the tick where tick_cnt = OVERSAMPLE/2-1.
  - Sampled bit = 0: go to DATA, clear tick_cnt and bit_cnt.
  - Sampled bit = 1: false start; go to IDLE, drop rx_baud_en, do not pulse done.
- DATA:
  - A bit decision is taken each time tick_cnt = OVERSAMPLE-1.
  - Each decided bit shifts in at the MSB of shift_reg, so the line's LSB-first order is preserved.
  - After DATA_BITS decisions go to PAR if PARITY != 0, otherwise to STOP.
- PAR:
  - One decision.
  - Stored error = XOR of data bits and parity bit. Even mode: error if the XOR is 1. Odd mode: error if the XOR is 0.
- STOP:
  - STOP_BITS decisions; any 0 sets the frame-error accumulator.
  - At the last stop-bit centre: load d_out, frame_err and parity_err, pulse done, clear busy and rx_baud_en, go to IDLE.
  - The receiver does not wait for the end of the stop bit, so it can resynchronise on a back-to-back next start.
- rx_en falling mid-frame: the frame completes normally.
- Reset, including mid-frame:
  - State returns to IDLE immediately.
  - All outputs go to 0: d_out = 0, start = 0, busy = 0, done = 0, rx_baud_en = 0, parity_err = 0, frame_err = 0.
  - Synchroniser flops reset to 1 (idle line).
- A sample_tick in IDLE is ignored.

## Timing
- d_in to rx_s: 2 clk. Start detection registers on the cycle after the edge appears on rx_s.
- Every decision is taken on the sample_tick cycle. The resulting state and output updates are visible one clk later.
- done is high for exactly one clk. It appears 1 clk after the tick of the last stop-bit centre.
- Frame length to done, in ticks:
  - OVERSAMPLE/2 for the start bit, plus
  - OVERSAMPLE × (DATA_BITS + parity bit + STOP_BITS).
- rx_baud_en rises 1 clk after start detection. It falls in the same cycle done rises.

## Configuration
- UART_RX_MAJORITY_EN defined:
  - Each decision is the 2-of-3 majority of rx_s captured at the ticks where tick_cnt = D-2, D-1 and D, with D the decision count.
  - Applies to start, data, parity and stop bits.
- Undefined: single sample of rx_s at the decision tick.
- Cycle timing is identical in both builds.

## Structure
- Shared package uart_pkg holds:
  - state encodings (IDLE, START, DATA, PAR, STOP);
  - parity mode constants PAR_NONE, PAR_EVEN, PAR_ODD.
- Sub-module uart_rx_sampler contains:
  - the 2-flop synchroniser, rx_q, and the falling-edge detect;
  - the 3-sample majority register, under the macro.
- The FSM, counters, shift register and error logic stay in uart_rx_cfg.

## Test plan
- 8N1, OVERSAMPLE = 8, byte 0x55 -> d_out = 0x55, one done pulse, frame_err = 0, busy low after done.
- 8E1, byte 0xA3 with correct parity bit 0 -> parity_err = 0. Same byte with parity bit 1 -> parity_err = 1, d_out = 0xA3.
- 7O2, second stop bit driven low -> frame_err = 1, done still pulses, next frame is received cleanly.
- Low glitch of 2 ticks on idle line -> false start, rx_baud_en falls, no done, state returns to IDLE. In the majority build, a single-tick glitch at a data-bit centre does not corrupt d_out.
- Line held low through a whole frame (break) -> d_out = 0x00, frame_err = 1, then no further start until the line returns high and falls again.
- rst asserted mid-DATA -> all outputs 0 immediately. Next frame 0xC3 after reset release -> d_out = 0xC3.
